// File: rtl/cnt_arbiter.sv
// cnt_arbiter: round-robin owner of one W-bit up-counter shared by four
// requesters; each grant runs CNT from 0 to the winner's LEN, then rotates.
//
// Ports:
//   CLK    in   1    rising-edge clock
//   RST_X  in   1    asynchronous active-low reset
//   REQ    in   4    level-sensitive requests
//   LEN    in   4*W  run lengths, requester i at LEN[i*W +: W]
//   GNT    out  4    one-hot grant while busy, else zero
//   OWNER  out  2    current or last granted requester
//   CNT    out  W    counter value
//   DONE   out  4    one-cycle completion pulse to the owner
//   BUSY   out  1    high outside IDLE

module cnt_arbiter #(
  parameter int W = 8
) (
  input  logic           CLK,
  input  logic           RST_X,
  input  logic [3:0]     REQ,
  input  logic [4*W-1:0] LEN,
  output logic [3:0]     GNT,
  output logic [1:0]     OWNER,
  output logic [W-1:0]   CNT,
  output logic [3:0]     DONE,
  output logic           BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   owner_q, owner_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic [W-1:0] cnt_q, cnt_d;

  logic [W-1:0] len_a [4];
  logic [1:0]   win;
  logic         win_vld;
  logic [3:0]   own_oh;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      len_a[i] = LEN[i*W +: W];
    end
  end

  // Scan from the far end back toward ptr so
  // the requester closest to ptr is the one kept.
  always_comb begin
    win_vld = 1'b0;
    win     = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (REQ[ptr_q + 2'(k)]) begin
        win_vld = 1'b1;
        win     = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          owner_d = win;
          tgt_d   = len_a[win];
          cnt_d   = '0;
          // A zero-length run has nothing to count.
          if (len_a[win] != '0) begin
            state_d = RUN;
          end else begin
            state_d = FIN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == tgt_q - 1'b1) begin
          state_d = FIN;
        end
      end
      FIN: begin
        ptr_d   = owner_q + 2'd1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign own_oh = 4'b0001 << owner_q;
  assign BUSY   = (state_q != IDLE);
  assign GNT    = BUSY ? own_oh : 4'b0000;
  assign DONE   = (state_q == FIN) ? own_oh : 4'b0000;
  assign OWNER  = owner_q;
  assign CNT    = cnt_q;

endmodule

// File: tb/tb_cnt_arbiter.sv
// tb_cnt_arbiter: directed and random stimulus for cnt_arbiter,
// checked every cycle against a run-level behavioural model.

module tb_cnt_arbiter;

  localparam int W = 8;

  logic           CLK;
  logic           RST_X;
  logic [3:0]     REQ;
  logic [4*W-1:0] LEN;
  logic [3:0]     GNT;
  logic [1:0]     OWNER;
  logic [W-1:0]   CNT;
  logic [3:0]     DONE;
  logic           BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  cnt_arbiter #(.W(W)) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .REQ   (REQ),
    .LEN   (LEN),
    .GNT   (GNT),
    .OWNER (OWNER),
    .CNT   (CNT),
    .DONE  (DONE),
    .BUSY  (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: a run is "granted" with elapsed step k; k runs 0..len,
  // and k==len is the completion cycle.
  bit m_busy;
  int m_own, m_len, m_k, m_ptr;

  always @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      m_busy = 0; m_own = 0; m_len = 0;
      m_k = 0; m_ptr = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (!m_busy && REQ[i]) begin
          m_busy = 1;
          m_own  = i;
          m_len  = int'(LEN[i*W +: W]);
          m_k    = 0;
        end
      end
    end else if (m_k == m_len) begin
      m_busy = 0;
      m_ptr  = (m_own + 1) % 4;
    end else begin
      m_k++;
    end
  end

  always @(negedge CLK) begin
    int eg, ed, ec;
    eg = m_busy ? (1 << m_own) : 0;
    ed = (m_busy && m_k == m_len) ? (1 << m_own) : 0;
    ec = m_busy ? m_k : m_len;
    chk("m_gnt", GNT, eg);
    chk("m_done", DONE, ed);
    chk("m_cnt", CNT, ec);
    chk("m_owner", OWNER, m_own);
    chk("m_busy", BUSY, m_busy);
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic set_len(input int i, input int v);
    LEN[i*W +: W] = W'(v);
  endtask

  function automatic int oh2i(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g == 4'(1 << i)) return i;
    return -1;
  endfunction

  // Waits for the next grant, then for its end; returns
  // owner, number of GNT-high cycles, and cycles waited.
  task automatic wait_grant(output int own, output int hi,
                            output int gap);
    gap = 0; hi = 0; own = -1;
    while (GNT == 4'b0 && gap < 20) begin step(); gap++; end
    if (GNT == 4'b0) begin
      chk("grant_timeout", 0, 1);
      return;
    end
    own = oh2i(GNT);
    while (GNT != 4'b0 && hi < 300) begin hi++; step(); end
    if (GNT != 4'b0) chk("run_timeout", 0, 1);
  endtask

  initial begin
    int own, hi, gap;
    int exp_seq[5];
    REQ = 4'b0; LEN = '0; RST_X = 1'b0;
    repeat (3) step();
    RST_X = 1'b1;
    step();
    chk("rst_gnt", GNT, 0);
    chk("rst_done", DONE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_cnt", CNT, 0);
    chk("rst_owner", OWNER, 0);

    // single run, length 3
    REQ = 4'b0010; set_len(1, 3);
    step(); REQ = 4'b0;
    chk("s_gnt", GNT, 4'b0010);
    chk("s_cnt0", CNT, 0);
    step(); chk("s_cnt1", CNT, 1);
    step(); chk("s_cnt2", CNT, 2);
    chk("s_done_lo", DONE, 0);
    step(); chk("s_cnt3", CNT, 3);
    chk("s_done", DONE, 4'b0010);
    step(); chk("s_idle_gnt", GNT, 0);
    chk("s_idle_cnt", CNT, 3);

    // zero length
    REQ = 4'b1000; set_len(3, 0);
    step(); REQ = 4'b0;
    chk("z_gnt", GNT, 4'b1000);
    chk("z_done", DONE, 4'b1000);
    chk("z_cnt", CNT, 0);
    step(); chk("z_idle", GNT, 0);

    // fairness: all request, all length 2
    LEN = '0;
    for (int i = 0; i < 4; i++) set_len(i, 2);
    REQ = 4'b1111;
    exp_seq = '{0, 1, 2, 3, 0};
    for (int r = 0; r < 5; r++) begin
      wait_grant(own, hi, gap);
      chk("f_owner", own, exp_seq[r]);
      chk("f_hi", hi, 3);
      chk("f_gap", gap, 1);
    end
    REQ = 4'b0;

    // hog on 0, requester 2 joins during run 0
    REQ = 4'b0001; set_len(0, 3); set_len(2, 1);
    step(); REQ = 4'b0101;
    wait_grant(own, hi, gap);
    chk("h_own0", own, 0);
    wait_grant(own, hi, gap);
    chk("h_own2", own, 2);
    wait_grant(own, hi, gap);
    chk("h_own0b", own, 0);
    REQ = 4'b0;

    // mid-run REQ/LEN change ignored
    REQ = 4'b0100; set_len(2, 4);
    step(); REQ = 4'b0;
    for (int i = 0; i < 4; i++) set_len(i, 9);
    for (int c = 0; c < 4; c++) begin
      chk("mr_cnt", CNT, c);
      chk("mr_nodone", DONE, 0);
      step();
    end
    chk("mr_fin", CNT, 4);
    chk("mr_done", DONE, 4'b0100);
    step(); chk("mr_idle", DONE, 0);

    // reset mid-run at CNT=5
    REQ = 4'b0001; set_len(0, 10);
    step(); REQ = 4'b0;
    repeat (5) step();
    chk("rr_cnt5", CNT, 5);
    #2 RST_X = 1'b0;
    #1;
    chk("rr_gnt", GNT, 0);
    chk("rr_cnt", CNT, 0);
    chk("rr_busy", BUSY, 0);
    chk("rr_done", DONE, 0);
    step(); step();
    RST_X = 1'b1;
    step();

    // one maximum-length run
    REQ = 4'b0010; set_len(1, 255);
    step(); REQ = 4'b0;
    repeat (255) step();
    chk("max_cnt", CNT, 255);
    chk("max_done", DONE, 4'b0010);
    step();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      REQ = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) REQ = 4'b0;
      for (int i = 0; i < 4; i++)
        set_len(i, $urandom_range(0, 6));
      step();
    end
    REQ = 4'b0;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cnt_arbiter.md
# cnt_arbiter

Round-robin controller that shares one W-bit up-counter between four requesters. Each requester asks for a counting run of a given length; the block grants one requester at a time, sequences the count from 0 to the requested length, signals completion, then rotates priority. It sits between client logic and the counter datapath, and replaces free-running counting with scheduled, length-bounded runs.

## Interface
- W, default 8: counter and length width in bits.
- CLK  in  1: clock; all state updates on the rising edge.
- RST_X  in  1: asynchronous active-low reset.
- REQ  in  4: per-requester request, level-sensitive.
- LEN  in  4*W: per-requester run length; requester i uses LEN[i*W +: W].
- GNT  out  4: one-hot grant, or all zero.
- OWNER  out  2: index of the current or last granted requester.
- CNT  out  W: current count value.
- DONE  out  4: one-cycle completion pulse, one-hot, to the owner.
- BUSY  out  1: high whenever the state is not IDLE.

## Operation
- States: IDLE, RUN, FIN. Registers: state, ptr (2-bit priority pointer), owner, tgt (W bits), CNT.
- Reset (asynchronous, RST_X=0) sets:
  - state=IDLE, ptr=0, OWNER=0, tgt=0.
  - CNT=0, GNT=0, DONE=0, BUSY=0.
  - Reset takes effect immediately mid-run: no DONE pulse, and the run is lost.
- IDLE:
  - If REQ==0, stay in IDLE and hold CNT.
  - Otherwise pick the first set REQ bit scanning ptr, ptr+1, ... modulo 4. Then load owner, load tgt=LEN of the winner, set CNT=0, and assert GNT[winner].
  - If the latched tgt != 0, go to RUN. If tgt == 0, go directly to FIN.
- RUN:
  - CNT increments by 1 each cycle.
  - When CNT == tgt-1, the next state is FIN and CNT becomes tgt.
  - REQ and LEN changes are ignored. The run always completes.
- FIN (one cycle):
  - DONE[owner]=1, GNT still asserted, CNT holds its final value (tgt).
  - ptr is set to owner+1 (mod 4). The next state is IDLE.
- In IDLE after FIN, GNT=0 and CNT keeps the last final value until the next grant.
- CNT never exceeds tgt ≤ 2^W-1, so it never wraps.
- Withdrawing REQ before a grant removes the requester from arbitration, with no side effects.

## Timing
- Grant latency: REQ high in an IDLE cycle gives GNT high in the next cycle.
- Granted period for length L≥1: L RUN cycles showing CNT=0..L-1, then 1 FIN cycle showing CNT=L. GNT is high for L+1 cycles.
- L=0: GNT is high for exactly 1 cycle (FIN), with CNT=0 and DONE pulsed.
- Back-to-back: FIN at cycle t, IDLE at t+1 (arbitration), next GNT at t+2. Minimum spacing between grants is one GNT-low cycle.
- Exactly one bit of GNT is high whenever BUSY=1. GNT==0 whenever BUSY=0.
- DONE is high only in FIN, exactly one cycle, on the same bit as GNT.
- LEN is sampled only in the arbitrating IDLE cycle.
- Simultaneous requests are resolved purely by ptr rotation. A requester holding REQ continuously cannot starve others: it waits at most 3 other runs.

## Test plan
- Reset: hold RST_X=0 for 3 cycles, then release → GNT=0, DONE=0, BUSY=0, CNT=0, OWNER=0. Assert RST_X=0 mid-RUN with CNT=5 → all outputs return to 0 immediately and no DONE pulse occurs.
- Single run: REQ=4'b0010 for one cycle with LEN[1]=3 → next cycle GNT=0010 with CNT=0,1,2. Then FIN: CNT=3, DONE=0010. Then IDLE: GNT=0, CNT stays 3.
- Zero length: REQ=4'b1000 with LEN[3]=0 → one cycle GNT=1000, DONE=1000, CNT=0, then IDLE.
- Fairness: REQ=4'b1111 held continuously with all LEN=2 → grants 0,1,2,3,0, each GNT high 3 cycles, separated by 1 idle cycle.
- Rotation with a hog: REQ[0] held continuously, REQ[2] raised during run 0 → the next grant goes to 2, then back to 0.
- Mid-run changes: during a LEN=4 run, drop REQ and change LEN → the run still counts 0..3, FIN shows 4, DONE pulses once.
